sram_like_mem_slave: RTL
========================

# sram_like_mem_slave

- Instruction-side memory responder that sits directly upstream of the IF stage.
- Accepts IF's SRAM-like requests (req / addr_ok / data_ok) into a small in-order request queue and services them against a 1-cycle synchronous word RAM.
- A programmable extra delay emulates slow memory, so IF's cancel/buffer logic can be exercised under controlled latency.
- Every accepted request is answered exactly once, in order; discarding cancelled data is IF's job, not this block's.

## Interface
Parameters:
- DEPTH, 2, max outstanding accepted-but-unanswered requests (power of 2, ≥1)
- DELAY, 0, extra wait cycles inserted before each RAM access (0..15)
- ADDR_W, 16, RAM word-address width; RAM index = inst_sram_addr[ADDR_W+1:2]

Ports:
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears queue, FSM, counters
- inst_sram_req  in  1  request valid
- inst_sram_wr  in  1  1 = write, 0 = read
- inst_sram_size  in  2  byte count code; not used in datapath, accepted for interface completeness
- inst_sram_wstrb  in  4  byte write enables (writes only)
- inst_sram_addr  in  32  byte address
- inst_sram_wdata  in  32  write data
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  one-cycle response pulse
- inst_sram_rdata  out  32  read data, valid with data_ok
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM word index
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

## Operation
- Queue: DEPTH-entry FIFO of {wr, wstrb, addr index, wdata}.
  - Pointers wrap modulo DEPTH; a count of 0..DEPTH tracks occupancy.
- Accept: addr_ok = req & (count < DEPTH) & ~reset, combinational.
  - A handshake occurs on a cycle with req & addr_ok; the entry is pushed at that posedge.
  - Full blocks acceptance even if a pop happens the same cycle; there is no bypass.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: count>0 -> WAIT if DELAY>0, else ACCESS; otherwise stay IDLE.
  - WAIT: the counter loads DELAY-1 on entry and decrements each cycle; at 0 -> ACCESS.
  - ACCESS: ram_en=1, with ram_addr, ram_wdata and ram_we taken from the queue head (ram_we = head.wstrb if head.wr, else 0). Pop the head, latch head.wr into resp_wr, -> RESP.
  - RESP: data_ok=1; rdata = resp_wr ? 0 : ram_rdata. Then count>0 -> WAIT/ACCESS (same rule as IDLE), else IDLE.
- Outside ACCESS: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Outside RESP: data_ok=0, rdata=0.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Responses are strictly in acceptance order, one data_ok per accepted request, writes included.
- Address bits above ADDR_W+1 are ignored (RAM index wraps); addr[1:0] is ignored.
- No backpressure exists on responses: data_ok is never stalled.

## Timing
- Reset values: addr_ok 0, data_ok 0, rdata 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0. The FSM goes to IDLE and the queue empties.
- Reset asserted mid-operation drops all queued and in-flight requests immediately (asynchronous). No data_ok follows for them.
- Latency, counting the handshake as cycle 0 with an empty queue and IDLE FSM: cycle 1 IDLE, cycle 2+DELAY ACCESS, cycle 3+DELAY data_ok.
- Sustained throughput: one response per 2+DELAY cycles.
- addr_ok can assert in the same cycle req rises; there is no registered lag.

## Test plan
- Single read, DELAY=0: preload mem[0]=0x02bffc63; req=1, wr=0, addr=0x1c000000 for one cycle (cycle 0) -> addr_ok=1 in cycle 0, ram_en=1 with ram_addr=0 in cycle 2, data_ok=1 with rdata=0x02bffc63 in cycle 3 only.
- Queue full, DEPTH=2: req held with addrs 0x0, 0x4, 0x8 from cycle 0 -> addr_ok=1 in cycles 0 and 1 and 0 in cycle 2. The third request is accepted once the count drops after the first ACCESS pop. data_ok pulses return mem[0], mem[1], mem[2] in order, 2 cycles apart.
- DELAY=3: single read at cycle 0 -> WAIT in cycles 2-4, ram_en in cycle 5, data_ok in cycle 6.
- Byte write: mem[4]=0x11223344; write addr 0x10, wstrb=4'b0011, wdata=0xaabbccdd -> ram_we=0011 in ACCESS, data_ok with rdata=0. A following read of 0x10 returns 0x1122ccdd.
- Reset mid-op: DELAY=3, accept a read, assert reset during WAIT -> data_ok stays 0 and addr_ok is 0 while reset is high. After release with req=0, no ram_en and no data_ok occur for 10 cycles.
- Idle: req=0 for 20 cycles -> addr_ok, ram_en and data_ok stay 0 throughout.

Source files
------------

// File: rtl/sram_like_mem_slave.sv
// Instruction-side SRAM-like responder: in-order request queue in front of a 1-cycle
// synchronous word RAM, with a programmable per-access delay to emulate slow memory.
module sram_like_mem_slave #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DELAY  = 0,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW     = $clog2(DEPTH + 1);
    localparam logic [3:0]  WaitLoad = (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              resp_wr_q;
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic              push, pop;

    logic              q_wr    [DEPTH];
    logic [3:0]        q_wstrb [DEPTH];
    logic [ADDR_W-1:0] q_idx   [DEPTH];
    logic [31:0]       q_wdata [DEPTH];

    // Size code and byte-offset/high address bits carry no meaning for this RAM.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_size, inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inst_sram_addr_ok = inst_sram_req & (count_q < CntW'(DEPTH)) & ~reset;
    assign push              = inst_sram_req & inst_sram_addr_ok;
    assign pop               = (state_q == StAccess);

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wptr_q]    <= inst_sram_wr;
            q_wstrb[wptr_q] <= inst_sram_wstrb;
            q_idx[wptr_q]   <= inst_sram_addr[ADDR_W+1:2];
            q_wdata[wptr_q] <= inst_sram_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wait_q    <= 4'd0;
            resp_wr_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop) begin
                rptr_q    <= ptr_inc(rptr_q);
                resp_wr_q <= q_wr[rptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (count_q != '0) begin
                    if (DELAY > 0) begin
                        state_d = StWait;
                        wait_d  = WaitLoad;
                    end else begin
                        state_d = StAccess;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (wait_q == 4'd0) state_d = StAccess;
                else                wait_d  = wait_q - 4'd1;
            end
            StAccess: state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_en            = 1'b0;
        ram_we            = 4'b0;
        ram_addr          = '0;
        ram_wdata         = 32'd0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        if (state_q == StAccess) begin
            ram_en    = 1'b1;
            ram_we    = q_wr[rptr_q] ? q_wstrb[rptr_q] : 4'b0;
            ram_addr  = q_idx[rptr_q];
            ram_wdata = q_wdata[rptr_q];
        end
        if (state_q == StResp) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = resp_wr_q ? 32'd0 : ram_rdata;
        end
    end

endmodule
